// File: rtl/camera_capture_ctrl_pkg.sv
// Shared definitions for the camera capture controller: register word
// addresses, CTRL/STATUS bit positions, FSM state encoding and the RGB
// packing helper used to build FIFO entries.
package camera_capture_ctrl_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_WIN_X     = 3'd2;
  localparam logic [2:0] ADDR_WIN_Y     = 3'd3;
  localparam logic [2:0] ADDR_DATA      = 3'd4;
  localparam logic [2:0] ADDR_FRAME_CNT = 3'd5;

  // CTRL bits
  localparam int CTRL_W      = 3;
  localparam int CTRL_ARM    = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_LVL_LSB = 8;

  // Window coordinate field offsets inside WIN_X / WIN_Y
  localparam int WIN_LO_LSB = 0;
  localparam int WIN_HI_LSB = 16;

  // Capture FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;

  function automatic logic [23:0] pack_rgb(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/capture_pixel_fifo.sv
// Synchronous show-ahead FIFO for captured RGB pixels.
//  clk, reset_n      : clock, asynchronous active-low reset
//  i_flush           : discard all contents (wins over push/pop)
//  i_push, i_din     : write request and data; accepted when not full, or
//                      when full and a pop happens in the same cycle
//  i_pop             : read request; ignored when empty
//  o_head            : current head entry (valid only when !o_empty)
//  o_full, o_empty   : occupancy flags
//  o_level           : number of stored entries, 0..DEPTH
module capture_pixel_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_din,
  output logic [DATA_W-1:0]        o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  // Pop frees a slot first, so a full FIFO can accept a push in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are meaningful, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/camera_capture_ctrl.sv
// Avalon-MM slave that captures a programmable window of camera pixels into
// a FIFO of packed RGB words for software readout.
//  clk, reset_n                     : clock, asynchronous active-low reset
//  address/chipselect/read/write_n  : Avalon-MM slave strobes
//  writedata / readdata             : register data (readdata registered, latency 1)
//  red_in/green_in/blue_in          : 8-bit camera channels
//  pix_valid                        : channels carry a pixel this cycle
//  frame_start                      : frame start pulse, coincident pixel is (0,0)
//  irq                              : level interrupt = done & irq_en, registered
module camera_capture_ctrl
  import camera_capture_ctrl_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter int CNT_W      = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  input  logic        pix_valid,
  input  logic        frame_start,
  output logic        irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        r_state;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_x0, r_x1, r_y0, r_y1;
  logic [CNT_W-1:0]  r_col, r_row;
  logic              r_done, r_ovf;
  logic [31:0]       r_frame_cnt;

  logic              w_wr, w_rd;
  logic              w_wr_ctrl, w_wr_status;
  logic              w_busy, w_cont, w_abort, w_start;
  logic [CNT_W-1:0]  w_pix_col, w_pix_row;
  logic              w_in_win, w_eligible, w_sof_end;
  logic              w_push_req, w_last, w_done_evt;
  logic              w_pop, w_drop;
  logic [1:0]        w_state_nxt;
  logic [31:0]       w_rdata;
  logic [23:0]       w_head;
  logic              w_full, w_empty;
  logic [LVL_W-1:0]  w_level;
  logic              w_unused;

  assign w_unused = ^writedata;

  assign w_wr        = chipselect && !write_n;
  assign w_rd        = chipselect && read;
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_wr_status = w_wr && (address == ADDR_STATUS);

  assign w_busy  = (r_state != ST_IDLE);
  assign w_cont  = r_ctrl[CTRL_CONT];
  assign w_abort = w_wr_ctrl && !writedata[CTRL_ARM] && w_busy;
  assign w_start = w_wr_ctrl &&  writedata[CTRL_ARM] && !w_busy;

  // Position of the pixel on the inputs this cycle; frame_start pins it to the origin.
  assign w_pix_col = frame_start ? '0 : r_col;
  assign w_pix_row = frame_start ? '0 : r_row;

  assign w_in_win = (w_pix_col >= r_x0) && (w_pix_col <= r_x1) &&
                    (w_pix_row >= r_y0) && (w_pix_row <= r_y1);

  // The frame_start pixel belongs to the new frame: it is captured when the
  // pulse opens a capture (from WAIT_SOF, or a continuous restart), not when
  // the pulse merely closes a single-shot capture.
  assign w_sof_end  = (r_state == ST_CAPTURE) && frame_start;
  assign w_eligible = ((r_state == ST_WAIT_SOF) && frame_start) ||
                      ((r_state == ST_CAPTURE) && (!frame_start || w_cont));
  assign w_push_req = w_eligible && pix_valid && w_in_win && !w_abort;

  // Reaching (x1,y1) finishes the window even if that pixel is dropped on overflow.
  assign w_last     = w_push_req && (w_pix_col == r_x1) && (w_pix_row == r_y1);
  assign w_done_evt = (w_sof_end && !w_abort) || w_last;

  assign w_pop  = w_rd && (address == ADDR_DATA) && !w_empty;
  assign w_drop = w_push_req && w_full && !w_pop;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) w_state_nxt = ST_WAIT_SOF;
        ST_WAIT_SOF: begin
          if (w_last)           w_state_nxt = w_cont ? ST_WAIT_SOF : ST_IDLE;
          else if (frame_start) w_state_nxt = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (w_last)           w_state_nxt = w_cont ? ST_WAIT_SOF : ST_IDLE;
          else if (frame_start) w_state_nxt = w_cont ? ST_CAPTURE : ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_CTRL: w_rdata[CTRL_W-1:0] = r_ctrl;
      ADDR_STATUS: begin
        w_rdata[STAT_BUSY]            = w_busy;
        w_rdata[STAT_DONE]            = r_done;
        w_rdata[STAT_OVF]             = r_ovf;
        w_rdata[STAT_LVL_LSB +: 8]    = 8'(w_level);
      end
      ADDR_WIN_X: begin
        w_rdata[WIN_LO_LSB +: CNT_W] = r_x0;
        w_rdata[WIN_HI_LSB +: CNT_W] = r_x1;
      end
      ADDR_WIN_Y: begin
        w_rdata[WIN_LO_LSB +: CNT_W] = r_y0;
        w_rdata[WIN_HI_LSB +: CNT_W] = r_y1;
      end
      ADDR_DATA:      w_rdata = w_empty ? 32'h0 : {8'h00, w_head};
      ADDR_FRAME_CNT: w_rdata = r_frame_cnt;
      default:        w_rdata = '0;
    endcase
  end

  // Column/row tracking runs in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pix_valid) begin
      if (w_pix_col == CNT_W'(LINE_WIDTH - 1)) begin
        r_col <= '0;
        r_row <= w_pix_row + CNT_W'(1);
      end else begin
        r_col <= w_pix_col + CNT_W'(1);
        r_row <= w_pix_row;
      end
    end else if (frame_start) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_ctrl      <= '0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_ctrl) r_ctrl <= writedata[CTRL_W-1:0];
      // A finished single-shot capture disarms itself.
      if (w_done_evt && !w_cont) r_ctrl[CTRL_ARM] <= 1'b0;
      if (w_wr && (address == ADDR_WIN_X)) begin
        r_x0 <= writedata[WIN_LO_LSB +: CNT_W];
        r_x1 <= writedata[WIN_HI_LSB +: CNT_W];
      end
      if (w_wr && (address == ADDR_WIN_Y)) begin
        r_y0 <= writedata[WIN_LO_LSB +: CNT_W];
        r_y1 <= writedata[WIN_HI_LSB +: CNT_W];
      end
      // Sticky flags: a same-cycle set beats the write-1-to-clear.
      r_done <= (r_done && !(w_wr_status && writedata[STAT_DONE])) || w_done_evt;
      r_ovf  <= (r_ovf  && !(w_wr_status && writedata[STAT_OVF]))  || w_drop;
      if (w_done_evt) r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= w_rdata;
      irq      <= r_done && r_ctrl[CTRL_IRQ_EN];
    end
  end

  capture_pixel_fifo #(
    .DATA_W (24),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (w_abort),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_din   (pack_rgb(red_in, green_in, blue_in)),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed-sequence bench with randomized pixel data and pixel spacing.
// Expected FIFO contents come from a scan-order model: pixel k of a frame sits
// at (k % LINE_WIDTH, k / LINE_WIDTH); in-window pixels up to (x1,y1) are
// queued while fewer than 16 are held, the rest flag overflow.
`timescale 1ns/1ps
module tb_camera_capture_ctrl;

  localparam int LW    = 640;
  localparam int DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  red_in, green_in, blue_in;
  logic        pix_valid;
  logic        frame_start;
  logic        irq;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] exp_q[$];
  logic [23:0] frame_pix [1024];
  logic        exp_done;
  logic        exp_ovf;
  logic [31:0] exp_cnt;

  camera_capture_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .read        (read),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic status_check(input string tag, input logic busy);
    logic [31:0] e;
    e = (32'(exp_q.size()) << 8) | {29'd0, exp_ovf, exp_done, busy};
    rd_check(tag, 3'd1, e);
  endtask

  task automatic clear_status();
    bus_wr(3'd1, 32'h6);
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      rd_check(tag, 3'd4, {8'h00, exp_q.pop_front()});
    end
  endtask

  // Streams npix pixels of a new frame with random data and random idle gaps,
  // updating the model for a window [x0,x1] x [y0,y1].
  task automatic send_frame(input int npix, input int x0, input int x1,
                            input int y0, input int y1);
    bit ended;
    int col, row;
    ended = 1'b0;
    for (int k = 0; k < npix; k++) begin
      frame_pix[k] = 24'($urandom);
      col = k % LW;
      row = k / LW;
      if (!ended && col >= x0 && col <= x1 && row >= y0 && row <= y1) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(frame_pix[k]);
        else                      exp_ovf = 1'b1;
        if (col == x1 && row == y1) begin
          ended    = 1'b1;
          exp_done = 1'b1;
          exp_cnt  = exp_cnt + 32'd1;
        end
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        pix_valid = 1'b0; frame_start = 1'b0;
      end
      @(negedge clk);
      pix_valid   = 1'b1;
      frame_start = (k == 0);
      {red_in, green_in, blue_in} = frame_pix[k];
    end
    @(negedge clk);
    pix_valid = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [23:0] v;

    reset_n = 1'b0;
    address = '0; chipselect = 1'b0; read = 1'b0; write_n = 1'b1; writedata = '0;
    red_in = '0; green_in = '0; blue_in = '0; pix_valid = 1'b0; frame_start = 1'b0;
    exp_done = 1'b0; exp_ovf = 1'b0; exp_cnt = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset values
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    for (int a = 0; a < 8; a++) rd_check($sformatf("reset_reg%0d", a), 3'(a), 32'd0);
    bus_wr(3'd6, 32'hFFFF_FFFF);
    rd_check("unmapped_write_ignored", 3'd6, 32'd0);

    // Single-shot capture across two lines
    bus_wr(3'd2, (32'd3 << 16) | 32'd1);
    bus_wr(3'd3, (32'd1 << 16) | 32'd0);
    rd_check("win_x_readback", 3'd2, (32'd3 << 16) | 32'd1);
    bus_wr(3'd0, 32'h1);
    status_check("armed_busy", 1'b1);
    send_frame(650, 1, 3, 0, 1);
    status_check("t2_status", 1'b0);
    rd_check("t2_frame_cnt", 3'd5, exp_cnt);
    rd_check("t2_arm_cleared", 3'd0, 32'd0);
    check("t2_irq_disabled", {31'd0, irq}, 32'd0);
    drain("t2_data", 6);
    rd_check("t2_empty_data", 3'd4, 32'd0);
    status_check("t2_drained", 1'b0);

    // Overflow: 32 in-window pixels into a 16-deep FIFO
    clear_status();
    bus_wr(3'd2, (32'd31 << 16) | 32'd0);
    bus_wr(3'd3, 32'd0);
    bus_wr(3'd0, 32'h1);
    send_frame(40, 0, 31, 0, 0);
    status_check("t3_full_overflow", 1'b0);
    rd_check("t3_frame_cnt", 3'd5, exp_cnt);
    drain("t3_data", 16);
    status_check("t3_drained", 1'b0);

    // Continuous capture with interrupt
    clear_status();
    bus_wr(3'd2, (32'd3 << 16) | 32'd0);
    bus_wr(3'd0, 32'h7);
    for (int f = 0; f < 3; f++) begin
      send_frame(6, 0, 3, 0, 0);
      repeat (2) @(negedge clk);
      check($sformatf("t4_irq_set_f%0d", f), {31'd0, irq}, 32'd1);
      status_check($sformatf("t4_status_f%0d", f), 1'b1);
      drain($sformatf("t4_data_f%0d", f), 4);
      if (f < 2) begin
        bus_wr(3'd1, 32'h2);
        exp_done = 1'b0;
        @(negedge clk);
        check($sformatf("t4_irq_clear_f%0d", f), {31'd0, irq}, 32'd0);
      end
    end
    rd_check("t4_frame_cnt", 3'd5, exp_cnt);
    bus_wr(3'd0, 32'h0);
    status_check("t4_stopped", 1'b0);

    // Abort mid-capture flushes the FIFO, keeps FRAME_CNT
    clear_status();
    bus_wr(3'd2, (32'd100 << 16) | 32'd0);
    bus_wr(3'd0, 32'h1);
    send_frame(5, 0, 100, 0, 0);
    status_check("t5_before_abort", 1'b1);
    bus_wr(3'd0, 32'h0);
    exp_q.delete();
    status_check("t5_after_abort", 1'b0);
    rd_check("t5_frame_cnt", 3'd5, exp_cnt);
    rd_check("t5_empty_data", 3'd4, 32'd0);

    // Full FIFO: pop and push in the same cycle, no overflow
    bus_wr(3'd2, (32'd63 << 16) | 32'd0);
    bus_wr(3'd0, 32'h1);
    send_frame(16, 0, 63, 0, 0);
    status_check("t6_full", 1'b1);
    v = 24'($urandom);
    @(negedge clk);
    address = 3'd4; chipselect = 1'b1; read = 1'b1;
    pix_valid = 1'b1; {red_in, green_in, blue_in} = v;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read = 1'b0; pix_valid = 1'b0;
    check("t6_pop_head", d, {8'h00, exp_q.pop_front()});
    exp_q.push_back(v);
    status_check("t6_level_kept", 1'b1);
    drain("t6_data", 16);
    bus_wr(3'd0, 32'h0);

    // Asynchronous reset in the middle of a capture
    bus_wr(3'd2, (32'd100 << 16) | 32'd0);
    bus_wr(3'd0, 32'h5);
    send_frame(4, 0, 100, 0, 0);
    bus_rd(3'd5, d);
    address = 3'd5;
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_reset_readdata", readdata, 32'd0);
    check("t7_reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete(); exp_done = 1'b0; exp_ovf = 1'b0; exp_cnt = '0;
    status_check("t7_status", 1'b0);
    rd_check("t7_frame_cnt", 3'd5, exp_cnt);
    rd_check("t7_ctrl", 3'd0, 32'd0);
    rd_check("t7_win_x", 3'd2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
